sub_64: RTL and testbench



---
 rtl/alu_pkg.sv | 13 +
 rtl/fa_cell.sv | 13 +
 rtl/sub_64.sv | 52 +++++
 tb/tb_sub_64.sv | 119 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the Y86-64 ALU family: word width and function codes.
package alu_pkg;

   localparam int unsigned WORD_W = 64;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_XOR = 2'b11
   } alu_fn_e;

endpackage

// File: rtl/fa_cell.sv
// 1-bit full adder, the ripple element of the ALU arithmetic chains.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/sub_64.sv
// Registered two's-complement subtractor s = a - b with signed-overflow flag.
// Built as a ripple of full-adder cells on a + ~b + 1; one cycle of latency.
module sub_64
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       control,
   output logic [WIDTH-1:0] s,
   output logic             overflow
);

   logic [WIDTH-1:0] b_inv;
   logic [WIDTH-1:0] diff;
   logic [WIDTH:0]   carry;
   logic             ovf_c;
   logic             unused_ok;

   assign b_inv    = ~b;
   assign carry[0] = 1'b1;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
      fa_cell u_fa (
         .a    (a[i]),
         .b    (b_inv[i]),
         .cin  (carry[i]),
         .sum  (diff[i]),
         .cout (carry[i+1])
      );
   end

   // Overflow only when operand signs differ and the result sign departs from a.
   assign ovf_c = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);

   // control is interface-only; the final carry-out has no consumer.
   assign unused_ok = ^{control, carry[WIDTH]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s        <= '0;
         overflow <= 1'b0;
      end else begin
         s        <= diff;
         overflow <= ovf_c;
      end
   end

endmodule

// File: tb/tb_sub_64.sv
// Directed and random self-checking bench for sub_64.
module tb_sub_64;

   logic        clk;
   logic        rst_n;
   logic [63:0] a;
   logic [63:0] b;
   logic [1:0]  control;
   logic [63:0] s;
   logic        overflow;

   int unsigned n_tests;
   int unsigned n_fail;

   sub_64 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a),
      .b        (b),
      .control  (control),
      .s        (s),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Apply one operand pair, clock it in, and compare against hand-given values.
   task automatic op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                     input logic [63:0] exp_s, input logic exp_ovf);
      a = av;
      b = bv;
      @(posedge clk);
      #1;
      check({tag, ".s"}, s, exp_s);
      check({tag, ".ovf"}, 64'(overflow), 64'(exp_ovf));
   endtask

   // Reference model: native subtraction plus the signed-overflow rule.
   task automatic op_model(input string tag, input logic [63:0] av, input logic [63:0] bv);
      logic [63:0] d;
      logic        v;
      d = av - bv;
      v = (av[63] ^ bv[63]) & (d[63] ^ av[63]);
      op(tag, av, bv, d, v);
   endtask

   localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
   localparam logic [63:0] MAX = 64'h7FFF_FFFF_FFFF_FFFF;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      control = 2'b01;
      rst_n   = 1'b0;
      a       = 64'hDEAD_BEEF_1234_5678;
      b       = 64'h0BAD_F00D_8765_4321;

      repeat (2) begin
         @(posedge clk);
         #1;
         check("reset.s", s, 64'h0);
         check("reset.ovf", 64'(overflow), 64'h0);
      end
      rst_n = 1'b1;

      op("five_minus_three", 64'd5, 64'd3, 64'd2, 1'b0);
      op("zero_minus_one", 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      op("one_minus_zero", 64'd1, 64'd0, 64'd1, 1'b0);
      op("one_minus_one", 64'd1, 64'd1, 64'd0, 1'b0);
      op("neg16_minus_big", 64'hFFFF_FFFF_FFFF_FFF0, 64'h7FFF_FFFF_FFFF_FFFE,
         64'h7FFF_FFFF_FFFF_FFF2, 1'b1);
      op("min_minus_one", MIN, 64'd1, MAX, 1'b1);
      op("zero_minus_min", 64'd0, MIN, MIN, 1'b1);
      op("max_minus_neg1", MAX, 64'hFFFF_FFFF_FFFF_FFFF, MIN, 1'b1);
      op("min_minus_min", MIN, MIN, 64'd0, 1'b0);
      op("max_minus_min", MAX, MIN, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      op("neg1_minus_max", 64'hFFFF_FFFF_FFFF_FFFF, MAX, MIN, 1'b0);

      // Back-to-back pairs with control X, then each defined code.
      control = 2'bxx;
      op_model("ctrl_x.a", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
      op_model("ctrl_x.b", MIN, 64'h7);
      op_model("ctrl_x.c", 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA);
      for (int c = 0; c < 4; c++) begin
         control = 2'(c);
         op_model("ctrl_code.a", {32'(c), 32'hFFFF_0000}, 64'h1_0000_0001);
         op_model("ctrl_code.b", 64'h7000_0000_0000_0000, 64'hF000_0000_0000_0000);
      end

      for (int i = 0; i < 10000; i++) begin
         control = 2'($urandom_range(0, 3));
         op_model("random", {$urandom, $urandom}, {$urandom, $urandom});
      end

      // Mid-stream reset discards the in-flight result.
      a       = MAX;
      b       = 64'hFFFF_FFFF_FFFF_FFFF;
      rst_n   = 1'b0;
      @(posedge clk);
      #1;
      check("midreset.s", s, 64'h0);
      check("midreset.ovf", 64'(overflow), 64'h0);
      rst_n = 1'b1;
      op("after_reset", 64'd100, 64'd58, 64'd42, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
